wb_stage_buffer: RTL and testbench
==================================

Name: wb_stage_buffer

Overview:
Parametrised write-back pipeline stage: a registered stage between memory and write-back with a valid/ready handshake and a 2-entry skid buffer. Carries the write-back result, base-register update value, both destination addresses and the write-back control bits. Supports synchronous flush and stall, and keeps in_ready fully registered, so no combinational ready path crosses the stage.

Parameters:
DATA_WIDTH, 32, width of wb_content and base_register_update_content
ADDR_WIDTH, 4, width of the register-file addresses
CTRL_WIDTH, 2, width of wb_control; must be >= 2. Bit0 = write wb_content to wb_add. Bit1 = write base update to reg_update_address. Upper bits are passed through.

Ports:
clock  input  1  single clock; all state changes on posedge
reset  input  1  synchronous, active-high; sampled on the posedge of clock
flush  input  1  synchronous; discards all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry; registered
wb_control_in  input  CTRL_WIDTH  control bits
wb_content_in  input  DATA_WIDTH  result value
base_register_update_content_in  input  DATA_WIDTH  base-register writeback value
wb_add_in  input  ADDR_WIDTH  result destination
reg_update_address_in  input  ADDR_WIDTH  base-register destination
out_valid  output  1  output entry valid
out_ready  input  1  write-back consumes the output entry
wb_control, wb_content, base_register_update_content, wb_add, reg_update_address  output  as the matching inputs  head-entry payload

Behaviour:
- Storage: main register (drives outputs) and skid register, each holding a full payload plus a valid bit. Occupancy states are EMPTY, ONE and FULL.
- Handshakes: accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is a registered function of the state.
- out_valid = 1 in ONE and FULL.
- Transitions:
  - EMPTY: accept -> main <= input; go to ONE.
  - ONE, accept & pop: main <= input; stay in ONE.
  - ONE, accept & ~pop: skid <= input; go to FULL.
  - ONE, ~accept & pop: go to EMPTY.
  - ONE, neither: hold.
  - FULL, pop: main <= skid; go to ONE. No accept occurs, since in_ready = 0.
  - FULL, ~pop: hold all state.
- Latency: 1 cycle from accept to out_valid when the stage is EMPTY, or ONE with a simultaneous pop. Throughput is 1 entry/cycle while out_ready is held high.
- Ordering: strictly FIFO. The skid entry is never emitted before the main entry.
- Stall (out_ready = 0): the output payload must stay stable while out_valid = 1.
- flush: the next state is EMPTY and both valid bits clear. flush beats accept and pop in the same cycle, so an entry presented with flush is dropped. Payload registers may keep stale data after a flush; they are don't-care while out_valid = 0.
- reset: the next state is EMPTY. out_valid = 0, in_ready = 1, and every payload output = 0. reset beats flush, and it aborts a FULL state mid-operation with no entry emitted.
- No arithmetic. All payload fields are passed through bit-exact at their parameter widths.
- in_valid while in_ready = 0 is ignored. Upstream holds the entry.

Optional Feature:
Macro WB_FWD_EN enables write-back forwarding. It adds these ports:
- fwd_addr  input  ADDR_WIDTH
- fwd_hit  output  1
- fwd_data  output  DATA_WIDTH

Forwarding is combinational from the main register only:
- If out_valid & wb_control[0] & (wb_add == fwd_addr): fwd_hit = 1, fwd_data = wb_content.
- Else if out_valid & wb_control[1] & (reg_update_address == fwd_addr): fwd_hit = 1, fwd_data = base_register_update_content.
- Otherwise: fwd_hit = 0, fwd_data = 0.

Without WB_FWD_EN these ports and their logic do not exist, and all other behaviour is identical.

Test Plan:
1. Assert reset for 2 cycles mid-stream while FULL -> out_valid = 0, in_ready = 1, all payload outputs = 0 on the first posedge after reset rises.
2. out_ready = 1; stream 4 entries with wb_content = 0x11,0x22,0x33,0x44 on consecutive cycles -> the same values appear 1 cycle later, one per cycle, and in_ready stays 1.
3. out_ready = 0; send 0xA0 then 0xB0 -> in_ready drops to 0 after the second accept, and the output holds 0xA0 stable. A third entry, 0xC0, held in_valid = 1, is not accepted. Raise out_ready -> outputs 0xA0, 0xB0, then 0xC0 after in_ready returns to 1.
4. In FULL, assert flush together with in_valid (0xDD) and out_ready -> out_valid = 0 next cycle, in_ready = 1, and 0xDD never appears.
5. WB_FWD_EN: main holds wb_control = 2'b11, wb_add = 3, reg_update_address = 5, wb_content = 0x100, base = 0x200. fwd_addr = 3 -> hit, 0x100. fwd_addr = 5 -> hit, 0x200. fwd_addr = 7 -> no hit. The same case with both addresses = 3 -> 0x100 (priority).
6. Parameter sweep at DATA_WIDTH = 64, ADDR_WIDTH = 5, CTRL_WIDTH = 3: random valid/ready traffic against a FIFO scoreboard -> no loss, no duplication, in-order, bit-exact payload including wb_control[2].

Source files
------------

// File: rtl/wb_stage_buffer.sv
// Write-back pipeline stage: valid/ready handshake, 2-entry skid buffer, registered in_ready.
// Optional write-back forwarding port is enabled by defining WB_FWD_EN.
module wb_stage_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int CTRL_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] wb_control_in,
  input  logic [DATA_WIDTH-1:0] wb_content_in,
  input  logic [DATA_WIDTH-1:0] base_register_update_content_in,
  input  logic [ADDR_WIDTH-1:0] wb_add_in,
  input  logic [ADDR_WIDTH-1:0] reg_update_address_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] wb_control,
  output logic [DATA_WIDTH-1:0] wb_content,
  output logic [DATA_WIDTH-1:0] base_register_update_content,
  output logic [ADDR_WIDTH-1:0] wb_add,
  output logic [ADDR_WIDTH-1:0] reg_update_address
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] content;
    logic [DATA_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] wb_add;
    logic [ADDR_WIDTH-1:0] upd_add;
  } payload_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t   state;
  payload_t main_q;
  payload_t skid_q;
  payload_t in_payload;
  logic     accept;
  logic     pop;

  assign in_payload = {wb_control_in, wb_content_in, base_register_update_content_in,
                       wb_add_in, reg_update_address_in};
  assign {wb_control, wb_content, base_register_update_content, wb_add, reg_update_address} = main_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // in_ready and out_valid are registered alongside the state so no ready path crosses the stage.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      // NOTE: payload registers are reset because the outputs must read zero after reset.
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= in_payload;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= in_payload;
          end else if (accept) begin
            skid_q   <= in_payload;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_FWD_EN
  // Forwarding looks at the head entry only; the result destination wins over the base update.
  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (out_valid && main_q.ctrl[0] && (main_q.wb_add == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = main_q.content;
    end else if (out_valid && main_q.ctrl[1] && (main_q.upd_add == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = main_q.base;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_buffer.sv
// Scoreboard bench for wb_stage_buffer at DATA_WIDTH=64, ADDR_WIDTH=5, CTRL_WIDTH=3.
// Forwarding checks are compiled in when WB_FWD_EN is defined.
module tb_wb_stage_buffer;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 3;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] content;
    logic [DW-1:0] base;
    logic [AW-1:0] wadd;
    logic [AW-1:0] radd;
  } pl_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  pl_t  in_p = '0;
  logic in_ready;
  logic out_valid;
  logic [CW-1:0] o_ctrl;
  logic [DW-1:0] o_content;
  logic [DW-1:0] o_base;
  logic [AW-1:0] o_wadd;
  logic [AW-1:0] o_radd;
  pl_t  out_p;
`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_a = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  assign out_p = {o_ctrl, o_content, o_base, o_wadd, o_radd};

  wb_stage_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wb_control_in(in_p.ctrl),
    .wb_content_in(in_p.content),
    .base_register_update_content_in(in_p.base),
    .wb_add_in(in_p.wadd),
    .reg_update_address_in(in_p.radd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wb_control(o_ctrl),
    .wb_content(o_content),
    .base_register_update_content(o_base),
    .wb_add(o_wadd),
    .reg_update_address(o_radd)
`ifdef WB_FWD_EN
    ,
    .fwd_addr(fwd_a),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data)
`endif
  );

  always #5 clock = ~clock;

  int  total = 0;
  int  bad = 0;
  pl_t exp_q[$];
  int  occ = 0;
  bit  last_rst = 1'b1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic pl_t rand_pl();
    pl_t p;
    p.ctrl    = CW'($urandom());
    p.content = {$urandom(), $urandom()};
    p.base    = {$urandom(), $urandom()};
    p.wadd    = AW'($urandom_range(0, 7));
    p.radd    = AW'($urandom_range(0, 7));
    return p;
  endfunction

  function automatic pl_t mk(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic [DW-1:0] b,
                             input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    pl_t p;
    p.ctrl = c; p.content = d; p.base = b; p.wadd = wa; p.radd = ra;
    return p;
  endfunction

`ifdef WB_FWD_EN
  function automatic logic [DW:0] exp_fwd(input bit v, input pl_t h, input logic [AW-1:0] a);
    if (v && h.ctrl[0] && h.wadd == a) return {1'b1, h.content};
    if (v && h.ctrl[1] && h.radd == a) return {1'b1, h.base};
    return '0;
  endfunction
`endif

  // One clock of stimulus; checks handshake outputs against the occupancy model, then advances it.
  task automatic cycle(input bit iv, input pl_t p, input bit ordy, input bit fl, input bit rst);
    bit acc;
    bit pp;
    @(posedge clock);
    #1;
    in_valid = iv; in_p = p; out_ready = ordy; flush = fl; reset = rst;
    @(negedge clock);
    check("in_ready", 256'(in_ready), 256'(occ < 2));
    check("out_valid", 256'(out_valid), 256'(occ > 0));
    if (last_rst) check("reset_payload", 256'(out_p), 256'(0));
    else if (!ordy && occ > 0) check("stall_head", 256'(out_p), 256'(exp_q[0]));
`ifdef WB_FWD_EN
    if (!ordy)
      check("fwd", 256'({fwd_hit, fwd_data}),
            256'(exp_fwd(occ > 0, (occ > 0) ? exp_q[0] : pl_t'('0), fwd_a)));
`endif
    if (rst || fl) begin
      occ = 0;
      exp_q.delete();
    end else begin
      acc = iv && (occ < 2);
      pp  = (occ > 0) && ordy;
      if (acc) exp_q.push_back(p);
      occ = occ + int'(acc) - int'(pp);
    end
    last_rst = rst;
  endtask

  // Monitor: every handshake at the output consumes the oldest expected entry.
  initial begin
    pl_t e;
    forever begin
      @(negedge clock);
      if (!reset && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 256'(out_p), 256'(0));
        end else begin
          e = exp_q.pop_front();
          check("payload", 256'(out_p), 256'(e));
        end
      end
    end
  end

  initial begin
    pl_t z;
    z = '0;
    // Reset from power-up, then reset again while FULL.
    cycle(0, z, 0, 0, 1);
    cycle(0, z, 0, 0, 0);
    cycle(1, rand_pl(), 0, 0, 0);
    cycle(1, rand_pl(), 0, 0, 0);
    cycle(1, rand_pl(), 0, 0, 1);
    cycle(0, z, 1, 0, 1);
    cycle(0, z, 1, 0, 0);

    // Streaming at full throughput.
    cycle(1, mk(3'b001, 64'h11, 64'h0, 5'd1, 5'd2), 1, 0, 0);
    cycle(1, mk(3'b101, 64'h22, 64'h0, 5'd1, 5'd2), 1, 0, 0);
    cycle(1, mk(3'b010, 64'h33, 64'h0, 5'd1, 5'd2), 1, 0, 0);
    cycle(1, mk(3'b111, 64'h44, 64'h0, 5'd1, 5'd2), 1, 0, 0);
    cycle(0, z, 1, 0, 0);
    cycle(0, z, 1, 0, 0);

    // Stall with skid fill; third entry held until space returns.
    cycle(1, mk(3'b001, 64'hA0, 64'h1, 5'd4, 5'd6), 0, 0, 0);
    cycle(1, mk(3'b001, 64'hB0, 64'h2, 5'd4, 5'd6), 0, 0, 0);
    cycle(1, mk(3'b001, 64'hC0, 64'h3, 5'd4, 5'd6), 0, 0, 0);
    cycle(1, mk(3'b001, 64'hC0, 64'h3, 5'd4, 5'd6), 0, 0, 0);
    cycle(1, mk(3'b001, 64'hC0, 64'h3, 5'd4, 5'd6), 1, 0, 0);
    cycle(1, mk(3'b001, 64'hC0, 64'h3, 5'd4, 5'd6), 1, 0, 0);
    cycle(0, z, 1, 0, 0);
    cycle(0, z, 1, 0, 0);
    check("stall_drained", 256'(exp_q.size()), 256'(0));

    // Flush in FULL drops the entry presented alongside it.
    cycle(1, mk(3'b001, 64'h51, 64'h0, 5'd0, 5'd0), 0, 0, 0);
    cycle(1, mk(3'b001, 64'h52, 64'h0, 5'd0, 5'd0), 0, 0, 0);
    cycle(1, mk(3'b001, 64'hDD, 64'h0, 5'd0, 5'd0), 1, 1, 0);
    cycle(0, z, 1, 0, 0);
    cycle(0, z, 1, 0, 0);

`ifdef WB_FWD_EN
    cycle(1, mk(3'b011, 64'h100, 64'h200, 5'd3, 5'd5), 0, 0, 0);
    fwd_a = 5'd3; cycle(0, z, 0, 0, 0);
    check("fwd_addr3", 256'({fwd_hit, fwd_data}), 256'({1'b1, 64'h100}));
    fwd_a = 5'd5; cycle(0, z, 0, 0, 0);
    check("fwd_addr5", 256'({fwd_hit, fwd_data}), 256'({1'b1, 64'h200}));
    fwd_a = 5'd7; cycle(0, z, 0, 0, 0);
    check("fwd_addr7", 256'({fwd_hit, fwd_data}), 256'(0));
    cycle(0, z, 0, 1, 0);
    cycle(1, mk(3'b011, 64'h100, 64'h200, 5'd3, 5'd3), 0, 0, 0);
    fwd_a = 5'd3; cycle(0, z, 0, 0, 0);
    check("fwd_priority", 256'({fwd_hit, fwd_data}), 256'({1'b1, 64'h100}));
    cycle(0, z, 1, 0, 0);
`endif

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
`ifdef WB_FWD_EN
      fwd_a = AW'($urandom_range(0, 7));
`endif
      cycle($urandom_range(0, 99) < 70, rand_pl(), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
    end
    for (int i = 0; i < 4; i++) cycle(0, z, 1, 0, 0);
    check("final_drain", 256'(exp_q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
